// File: rtl/pipelined_segmented_alu.sv
// ---------------------------------------------------------------------------
// pipelined_segmented_alu
//
// ALU whose carry chain is split into NSEG = WIDTH/SEG_W segments. Each
// segment is added in its own pipeline stage, so the block has NSEG+1
// register stages:
//   - the capture stage holds the operands, op, the initial carry and valid;
//   - each following stage adds one segment;
//   - the stage that adds the last segment is the output stage.
// A single global advance signal (!out_valid || out_ready) moves every
// stage together. When advance is low, the whole pipeline freezes.
//
// Parameters
//   WIDTH  operand/result width in bits
//   SEG_W  carry-chain segment width in bits (WIDTH must be a multiple)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   flush      synchronous discard of every in-flight transaction
//   in_valid   operand transaction offered
//   in_ready   block can accept a transaction this cycle
//   a, b       operands
//   cin        carry-in, used by ADC only
//   op         000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC,
//              110/111 reserved (result 0)
//   out_valid  result presented
//   out_ready  downstream accepts the result
//   result     operation result
//   carry_out, overflow, zero, negative  result flags
//   in_flight  valid transactions held in the pipeline, output stage included
// ---------------------------------------------------------------------------
module pipelined_segmented_alu #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    input  logic                                cin,
    input  logic [2:0]                          op,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    result,
    output logic                                carry_out,
    output logic                                overflow,
    output logic                                zero,
    output logic                                negative,
    output logic [$clog2(WIDTH/SEG_W+2)-1:0]    in_flight
);

    localparam int NSEG  = (SEG_W > 0) ? (WIDTH / SEG_W) : 1;
    localparam int CNT_W = $clog2(NSEG + 2);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_ADC = 3'b101;

    // Reject segmentations that do not tile the operand exactly.
    generate
        if ((SEG_W < 1) || ((WIDTH % SEG_W) != 0)) begin : g_bad_params
            $error("pipelined_segmented_alu: WIDTH must be a positive multiple of SEG_W");
        end
    endgenerate

    // One segment of the operation: {carry_out, segment_result}.
    // Logic and reserved ops never produce a carry.
    function automatic logic [SEG_W:0] seg_calc(
        input logic [2:0]       f_op,
        input logic [SEG_W-1:0] f_a,
        input logic [SEG_W-1:0] f_b,
        input logic             f_c
    );
        logic [SEG_W:0] r;
        r = {(SEG_W+1){1'b0}};
        case (f_op)
            OP_ADD, OP_ADC: r = {1'b0, f_a} + {1'b0, f_b}  + {{SEG_W{1'b0}}, f_c};
            OP_SUB:         r = {1'b0, f_a} + {1'b0, ~f_b} + {{SEG_W{1'b0}}, f_c};
            OP_AND:         r = {1'b0, f_a & f_b};
            OP_OR:          r = {1'b0, f_a | f_b};
            OP_XOR:         r = {1'b0, f_a ^ f_b};
            default:        r = {(SEG_W+1){1'b0}};
        endcase
        return r;
    endfunction

    // True for the ops whose carry/overflow flags are meaningful.
    function automatic logic is_arith(input logic [2:0] f_op);
        logic r;
        case (f_op)
            OP_ADD, OP_SUB, OP_ADC: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Pipeline stage state; index i feeds the addition of segment i.
    logic [NSEG-1:0]  vld_r;
    logic [NSEG-1:0]  cry_r;
    logic [WIDTH-1:0] a_r   [0:NSEG-1];
    logic [WIDTH-1:0] b_r   [0:NSEG-1];
    logic [WIDTH-1:0] res_r [0:NSEG-1];
    logic [2:0]       op_r  [0:NSEG-1];

    logic [SEG_W:0]   seg_s     [0:NSEG-1];
    logic [WIDTH-1:0] nxt_res_s [0:NSEG-1];
    logic             advance_s;
    logic             accept_s;
    logic             handoff_s;
    logic             cin0_s;
    logic             b_msb_eff_s;
    logic             carry_msb_s;
    logic             last_ov_s;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;
    assign accept_s  = in_valid && advance_s;
    assign handoff_s = out_valid && out_ready;

    // Initial carry: SUB is a + ~b + 1, ADC injects cin, everything else 0.
    always_comb begin
        cin0_s = 1'b0;
        case (op)
            OP_SUB:  cin0_s = 1'b1;
            OP_ADC:  cin0_s = cin;
            default: cin0_s = 1'b0;
        endcase
    end

    // Per-stage segment add and the partial result it produces.
    always_comb begin
        for (int i = 0; i < NSEG; i++) begin
            seg_s[i] = seg_calc(op_r[i], a_r[i][i*SEG_W +: SEG_W],
                                b_r[i][i*SEG_W +: SEG_W], cry_r[i]);
            nxt_res_s[i] = res_r[i];
            nxt_res_s[i][i*SEG_W +: SEG_W] = seg_s[i][SEG_W-1:0];
        end
    end

    // Signed overflow of the last segment: carry into the MSB xor carry out.
    // The carry into the MSB is recovered from the MSB sum bit and its inputs.
    always_comb begin
        b_msb_eff_s = 1'b0;
        carry_msb_s = 1'b0;
        last_ov_s   = 1'b0;
        if (op_r[NSEG-1] == OP_SUB) begin
            b_msb_eff_s = ~b_r[NSEG-1][WIDTH-1];
        end else begin
            b_msb_eff_s = b_r[NSEG-1][WIDTH-1];
        end
        carry_msb_s = nxt_res_s[NSEG-1][WIDTH-1] ^ a_r[NSEG-1][WIDTH-1] ^ b_msb_eff_s;
        if (is_arith(op_r[NSEG-1])) begin
            last_ov_s = carry_msb_s ^ seg_s[NSEG-1][SEG_W];
        end else begin
            last_ov_s = 1'b0;
        end
    end

    // Pipeline registers, output stage and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r     <= {NSEG{1'b0}};
            cry_r     <= {NSEG{1'b0}};
            for (int i = 0; i < NSEG; i++) begin
                a_r[i]   <= {WIDTH{1'b0}};
                b_r[i]   <= {WIDTH{1'b0}};
                res_r[i] <= {WIDTH{1'b0}};
                op_r[i]  <= 3'b000;
            end
            out_valid <= 1'b0;
            result    <= {WIDTH{1'b0}};
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            in_flight <= {CNT_W{1'b0}};
        end else if (flush) begin
            // Data registers keep their contents; only validity is discarded,
            // so the outputs keep showing the last presented values.
            vld_r     <= {NSEG{1'b0}};
            out_valid <= 1'b0;
            in_flight <= {CNT_W{1'b0}};
        end else begin
            if (advance_s) begin
                vld_r[0] <= in_valid;
                a_r[0]   <= a;
                b_r[0]   <= b;
                op_r[0]  <= op;
                cry_r[0] <= cin0_s;
                res_r[0] <= {WIDTH{1'b0}};
                for (int i = 1; i < NSEG; i++) begin
                    vld_r[i] <= vld_r[i-1];
                    a_r[i]   <= a_r[i-1];
                    b_r[i]   <= b_r[i-1];
                    op_r[i]  <= op_r[i-1];
                    cry_r[i] <= seg_s[i-1][SEG_W];
                    res_r[i] <= nxt_res_s[i-1];
                end
                out_valid <= vld_r[NSEG-1];
                // A bubble reaching the output leaves the last values in place.
                if (vld_r[NSEG-1]) begin
                    result    <= nxt_res_s[NSEG-1];
                    carry_out <= seg_s[NSEG-1][SEG_W];
                    overflow  <= last_ov_s;
                    zero      <= (nxt_res_s[NSEG-1] == {WIDTH{1'b0}});
                    negative  <= nxt_res_s[NSEG-1][WIDTH-1];
                end
            end
            case ({accept_s, handoff_s})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_segmented_alu.sv
// ---------------------------------------------------------------------------
// tb_pipelined_segmented_alu
//
// Scoreboard bench for pipelined_segmented_alu (WIDTH=32, SEG_W=8).
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge. Every accepted transaction pushes
// a reference result onto a queue, every handoff pops and compares it.
// ---------------------------------------------------------------------------
module tb_pipelined_segmented_alu;

    localparam int WIDTH = 32;
    localparam int SEG_W = 8;
    localparam int NSEG  = WIDTH / SEG_W;
    // Steps (cycles) from the accepting edge to the handoff edge, no stall.
    localparam int LAT   = NSEG + 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic [2:0]        op;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic              carry_out;
    logic              overflow;
    logic              zero;
    logic              negative;
    logic [2:0]        in_flight;

    pipelined_segmented_alu #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .in_flight (in_flight)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
        logic        n;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests;
    int          n_fail;
    int          cyc;
    int          peak_if;
    bit          check_lat;
    logic [31:0] last_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference ALU built directly from the arithmetic definitions.
    function automatic exp_t model(input logic [2:0] f_op, input logic [31:0] fa,
                                   input logic [31:0] fb, input logic fc);
        logic [32:0] s;
        exp_t        e;
        s    = 33'd0;
        e    = '0;
        case (f_op)
            3'd0: begin
                s    = {1'b0, fa} + {1'b0, fb};
                e.co = s[32];
                e.ov = (fa[31] == fb[31]) && (s[31] != fa[31]);
            end
            3'd5: begin
                s    = {1'b0, fa} + {1'b0, fb} + {32'd0, fc};
                e.co = s[32];
                e.ov = (fa[31] == fb[31]) && (s[31] != fa[31]);
            end
            3'd1: begin
                s    = {1'b0, fa} + {1'b0, ~fb} + 33'd1;
                e.co = s[32];
                e.ov = (fa[31] != fb[31]) && (s[31] != fa[31]);
            end
            3'd2:    s = {1'b0, fa & fb};
            3'd3:    s = {1'b0, fa | fb};
            3'd4:    s = {1'b0, fa ^ fb};
            default: s = 33'd0;
        endcase
        e.res = s[31:0];
        e.z   = (s[31:0] == 32'd0);
        e.n   = s[31];
        return e;
    endfunction

    // One clock cycle: inputs are already driven; check, book-keep, advance.
    task automatic step();
        exp_t e;
        #1;
        check_eq("in_flight", in_flight, sb.size());
        check_eq("in_ready", in_ready, (!out_valid || out_ready));
        if (int'(in_flight) > peak_if) peak_if = int'(in_flight);
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", out_valid, 1'b0);
                end else if ((cyc - sb[0].acc) < LAT) begin
                    check_eq("early_out", cyc - sb[0].acc, LAT);
                end
            end else begin
                check_eq("hold_result", result, last_res);
            end
        end
        if (rst) begin
            sb.delete();
            last_res = 32'd0;
        end else if (flush) begin
            if (out_valid && (sb.size() > 0)) last_res = sb[0].res;
            sb.delete();
        end else begin
            if (out_valid && out_ready && (sb.size() > 0)) begin
                e = sb.pop_front();
                check_eq("result", result, e.res);
                check_eq("carry_out", carry_out, e.co);
                check_eq("overflow", overflow, e.ov);
                check_eq("zero", zero, e.z);
                check_eq("negative", negative, e.n);
                if (check_lat) check_eq("latency", cyc - e.acc, LAT);
                last_res = e.res;
            end
            if (in_valid && in_ready) begin
                e     = model(op, a, b, cin);
                e.acc = cyc;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input logic [2:0] f_op, input logic [31:0] fa,
                         input logic [31:0] fb, input logic fc);
        in_valid = 1'b1;
        op       = f_op;
        a        = fa;
        b        = fb;
        cin      = fc;
        step();
    endtask

    // Empty the pipeline with a bounded wait, then confirm nothing else emerges.
    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int k = 0; (k < 60) && (sb.size() > 0); k++) step();
        check_eq("drain_timeout", sb.size(), 0);
        repeat (3) step();
    endtask

    initial begin
        int irl;
        int issued;
        int k;
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        peak_if   = 0;
        check_lat = 1'b0;
        last_res  = 32'd0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        cin       = 1'b0;
        op        = 3'd0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_in_flight", in_flight, 3'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_flags", {carry_out, overflow, zero, negative}, 4'b0000);
        @(negedge clk);

        // Directed operations, back to back, exact latency.
        check_lat = 1'b1;
        drive(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drive(3'd1, 32'h8000_0000, 32'h0000_0001, 1'b0);
        drive(3'd1, 32'h0000_0001, 32'h0000_0002, 1'b0);
        drive(3'd5, 32'h0000_00FF, 32'h0000_0000, 1'b1);
        drive(3'd4, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0);
        drive(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        drive(3'd3, 32'h1234_5678, 32'h8765_4321, 1'b0);
        drive(3'd6, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        drive(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        drive(3'd5, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        drive(3'd0, 32'h0000_0005, 32'h0000_0005, 1'b1);
        drain();

        // Eight ADDs with a three-cycle output stall mid-stream.
        check_lat = 1'b0;
        peak_if   = 0;
        irl       = 0;
        issued    = 0;
        k         = 0;
        while ((issued < 8) && (k < 40)) begin
            in_valid  = 1'b1;
            op        = 3'd0;
            a         = $urandom;
            b         = $urandom;
            cin       = 1'b0;
            out_ready = !((k >= 5) && (k < 8));
            #1;
            if (!in_ready) irl++;
            else issued++;
            step();
            k++;
        end
        check_eq("stall_ready_low", irl, 3);
        check_eq("peak_in_flight", peak_if, 5);
        drain();

        // Flush with three in flight plus a simultaneous offer.
        check_lat = 1'b1;
        drive(3'd0, 32'h0000_0010, 32'h0000_0020, 1'b0);
        drive(3'd1, 32'h0000_0030, 32'h0000_0001, 1'b0);
        drive(3'd4, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0);
        flush = 1'b1;
        drive(3'd0, 32'h0000_0040, 32'h0000_0002, 1'b0);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("flush_out_valid", out_valid, 1'b0);
        check_eq("flush_in_flight", in_flight, 3'd0);
        repeat (8) step();
        drive(3'd0, 32'h0000_0100, 32'h0000_0200, 1'b0);
        drain();

        // Reset while stalled with a full pipeline.
        check_lat = 1'b0;
        out_ready = 1'b0;
        for (int j = 0; j < 8; j++) drive(3'd1, $urandom, $urandom, 1'b0);
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(3'd0, 32'h0000_0001, 32'h0000_0001, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("mrst_out_valid", out_valid, 1'b0);
        check_eq("mrst_in_ready", in_ready, 1'b1);
        check_eq("mrst_in_flight", in_flight, 3'd0);
        check_eq("mrst_result", result, 32'd0);
        check_eq("mrst_flags", {carry_out, overflow, zero, negative}, 4'b0000);
        step();
        check_lat = 1'b1;
        drive(3'd1, 32'h0000_0003, 32'h0000_0005, 1'b0);
        drain();

        // Random traffic with occasional flushes.
        check_lat = 1'b0;
        for (int j = 0; j < 300; j++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            op        = 3'($urandom_range(0, 7));
            a         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b         = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stops advancing.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
